// File: rtl/aes_loader_pkg.sv
// Shared types and header-byte layout for the AES block loader.
package aes_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int          HDR_KEY_BIT   = 0;
  localparam int          HDR_DEC_BIT   = 1;
  localparam logic [7:0]  HDR_RSVD_MASK = 8'hFC;
  localparam int          BLK_BYTES     = 16;

  function automatic logic hdr_rsvd_clear(input logic [7:0] hdr);
    return (hdr & HDR_RSVD_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/aes_loader_timeout.sv
// Inter-byte idle counter for the loader; only built when AES_LOADER_TIMEOUT_EN is defined.
`ifdef AES_LOADER_TIMEOUT_EN
module aes_loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || clear) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle; an accepted byte wins.
  assign expired = run && !clear && (cnt == LAST);

endmodule
`endif

// File: rtl/aes_block_loader.sv
// Byte-stream frame parser assembling the AES key and 128-bit data block.
// Optional inter-byte timeout: define AES_LOADER_TIMEOUT_EN.
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int NK             = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [32*NK-1:0]  key,
  output logic              key_loaded,
  output logic [127:0]      blk_data,
  output logic              blk_decrypt,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic              err,
  output state_t            dbg_state
);

  localparam int KW = 32 * NK;
  localparam int CW = $clog2(4 * NK) + 1;
  localparam logic [CW-1:0] KEY_LAST  = CW'(4 * NK - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(BLK_BYTES - 1);

  // Handshakes: a byte moves on posedge when in_valid && in_ready; a block moves
  // when blk_valid && blk_ready. Senders hold their payload stable until then.

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [KW-1:0]    key_n;
  logic             key_loaded_n;
  logic [127:0]     blk_data_n;
  logic             blk_decrypt_n;
  logic             blk_valid_n;
  logic             err_n;
  logic             ready_en;
  logic             accept;
  logic             timeout;

  assign in_ready  = ready_en && (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

`ifdef AES_LOADER_TIMEOUT_EN
  logic running;
  assign running = (state == KEY) || (state == DATA);

  aes_loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .run     (running),
    .clear   (accept),
    .expired (timeout)
  );
`else
  // Never true; keeps the parameter referenced when the timeout is not built.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    key_n         = key;
    key_loaded_n  = key_loaded;
    blk_data_n    = blk_data;
    blk_decrypt_n = blk_decrypt;
    blk_valid_n   = blk_valid;
    err_n         = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (!hdr_rsvd_clear(in_data)) begin
            err_n = 1'b1;
          end else if (in_data[HDR_KEY_BIT]) begin
            key_loaded_n = 1'b0;
            cnt_n        = '0;
            state_n      = KEY;
          end else if (key_loaded) begin
            blk_decrypt_n = in_data[HDR_DEC_BIT];
            cnt_n         = '0;
            state_n       = DATA;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      KEY: begin
        if (accept) begin
          key_n = {key[KW-9:0], in_data};
          if (cnt == KEY_LAST) begin
            key_loaded_n = 1'b1;
            cnt_n        = '0;
            state_n      = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (timeout) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      DATA: begin
        if (accept) begin
          blk_data_n = {blk_data[119:0], in_data};
          if (cnt == DATA_LAST) begin
            blk_valid_n = 1'b1;
            cnt_n       = '0;
            state_n     = HOLD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else if (timeout) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      HOLD: begin
        if (blk_valid && blk_ready) begin
          blk_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      key         <= '0;
      key_loaded  <= 1'b0;
      blk_data    <= '0;
      blk_decrypt <= 1'b0;
      blk_valid   <= 1'b0;
      err         <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      key         <= key_n;
      key_loaded  <= key_loaded_n;
      blk_data    <= blk_data_n;
      blk_decrypt <= blk_decrypt_n;
      blk_valid   <= blk_valid_n;
      err         <= err_n;
      ready_en    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: directed steps plus random frames against a byte-level model.
module tb_aes_block_loader;
  import aes_loader_pkg::*;

  localparam int NK = 8;
  localparam int KW = 32 * NK;
  localparam int TO = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] key;
  logic          key_loaded;
  logic [127:0]  blk_data;
  logic          blk_decrypt;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          err;
  state_t        dbg_state;

  aes_block_loader #(.NK(NK), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .key         (key),
    .key_loaded  (key_loaded),
    .blk_data    (blk_data),
    .blk_decrypt (blk_decrypt),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic          mdl_key_loaded = 1'b0;
  int            exp_err  = 0;
  int            err_seen = 0;
  logic [7:0]    fb [32];
  logic [127:0]  last_blk;
  logic [128:0]  exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: one expected {decrypt, block} per accepted block
  always @(negedge clk) begin
    if (err === 1'b1) err_seen++;
    if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_blk", 256'(blk_valid), 256'(0));
      end else begin
        check("sb_block", 256'({blk_decrypt, blk_data}), 256'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] h);
    send_byte(h);
    if ((h & 8'hFC) != 8'h00) exp_err++;
    else if (h[0]) mdl_key_loaded = 1'b0;
    else if (!mdl_key_loaded) exp_err++;
  endtask

  task automatic send_key_frame(input logic [7:0] h);
    logic [KW-1:0] exp_key;
    send_hdr(h);
    for (int i = 0; i < 4*NK - 1; i++) send_byte(fb[i]);
    check("key_loaded_early", 256'(key_loaded), 256'(0));
    send_byte(fb[4*NK-1]);
    check("key_loaded_lat", 256'(key_loaded), 256'(1));
    for (int i = 0; i < 4*NK; i++) exp_key[KW-1-8*i -: 8] = fb[i];
    check("key_value", 256'(key), 256'(exp_key));
    mdl_key_loaded = 1'b1;
  endtask

  task automatic send_data_frame(input logic [7:0] h);
    send_hdr(h);
    for (int i = 0; i < 15; i++) send_byte(fb[i]);
    check("blk_valid_early", 256'(blk_valid), 256'(0));
    for (int i = 0; i < 16; i++) last_blk[127-8*i -: 8] = fb[i];
    exp_q.push_back({h[1], last_blk});
    send_byte(fb[15]);
    check("blk_valid_lat", 256'(blk_valid), 256'(1));
  endtask

  task automatic finish_block(input int d);
    int n = 0;
    repeat (d) @(negedge clk);
    blk_ready = 1'b1;
    @(negedge clk);
    while (blk_valid !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("blk_valid_drop", 256'(blk_valid), 256'(0));
    check("idle_after_blk", 256'(dbg_state), 256'(IDLE));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_key", 256'(key), 256'(0));
    check("rst_key_loaded", 256'(key_loaded), 256'(0));
    check("rst_blk_data", 256'(blk_data), 256'(0));
    check("rst_blk_dec", 256'(blk_decrypt), 256'(0));
    check("rst_blk_valid", 256'(blk_valid), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_state", 256'(dbg_state), 256'(IDLE));
    rst = 1'b0;
    mdl_key_loaded = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
  endtask

  task automatic check_err(input string tag);
    @(negedge clk);
    #1;
    check(tag, 256'(err_seen), 256'(exp_err));
  endtask

  initial begin
    do_reset();

    // 1: key load 00..1f
    for (int i = 0; i < 32; i++) fb[i] = 8'(i);
    send_key_frame(8'h01);
    check("t1_key_const", 256'(key), 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check_err("t1_no_err");

    // 2: encrypt block, ready already high
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) fb[i] = 8'(i * 8'h11);
    send_data_frame(8'h00);
    @(negedge clk);
    check("t2_valid", 256'(blk_valid), 256'(1));
    check("t2_data", 256'(blk_data), 256'(128'h00112233445566778899aabbccddeeff));
    check("t2_dec", 256'(blk_decrypt), 256'(0));
    @(negedge clk);
    check("t2_valid_1cyc", 256'(blk_valid), 256'(0));

    // 3: backpressure on a decrypt block
    blk_ready = 1'b0;
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom_range(0, 255));
    send_data_frame(8'h02);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t3_hold_valid", 256'(blk_valid), 256'(1));
      check("t3_hold_data", 256'(blk_data), 256'(last_blk));
      check("t3_hold_dec", 256'(blk_decrypt), 256'(1));
      check("t3_hold_ready", 256'(in_ready), 256'(0));
    end
    blk_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_drop", 256'(blk_valid), 256'(0));
    check("t3_idle", 256'(dbg_state), 256'(IDLE));
    check("t3_in_ready", 256'(in_ready), 256'(1));
    blk_ready = 1'b0;

    // 4: protocol errors
    send_hdr(8'h80);
    check_err("t4_rsvd_err");
    check("t4_idle", 256'(dbg_state), 256'(IDLE));
    do_reset();
    send_hdr(8'h00);
    check_err("t4_nokey_err");
    check("t4_idle2", 256'(dbg_state), 256'(IDLE));

    // 5: reset mid-key, then a full key frame
    send_hdr(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)));
    do_reset();
    for (int i = 0; i < 32; i++) fb[i] = 8'($urandom_range(0, 255));
    send_key_frame(8'h01);
    check_err("t5_err_total");

    // random frames
    for (int it = 0; it < 12; it++) begin
      int kind;
      kind = $urandom_range(0, 3);
      for (int i = 0; i < 32; i++) fb[i] = 8'($urandom_range(0, 255));
      if (kind == 0) begin
        send_key_frame($urandom_range(0, 1) ? 8'h03 : 8'h01);
      end else if (kind == 1) begin
        send_hdr(8'($urandom_range(4, 255)));
        check_err("rnd_rsvd_err");
      end else begin
        blk_ready = 1'b0;
        send_data_frame($urandom_range(0, 1) ? 8'h02 : 8'h00);
        finish_block($urandom_range(0, 4));
        blk_ready = 1'b0;
      end
    end

`ifdef AES_LOADER_TIMEOUT_EN
    // 6: abort a partial data frame by timeout
    begin
      int n = 0;
      int base;
      send_hdr(8'h00);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
      base = err_seen;
      repeat (15) @(negedge clk);
      #1 check("t6_no_early_err", 256'(err_seen), 256'(base));
      while (err_seen == base && n < 15) begin
        @(negedge clk);
        #1 n++;
      end
      exp_err++;
      check("t6_timeout_err", 256'(err_seen), 256'(exp_err));
      check("t6_idle", 256'(dbg_state), 256'(IDLE));
      check("t6_no_blk", 256'(blk_valid), 256'(0));
      for (int i = 0; i < 16; i++) fb[i] = 8'($urandom_range(0, 255));
      send_data_frame(8'h02);
      finish_block(1);
    end
`endif

    check_err("final_err_count");
    check("final_queue_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
